debug_uart_dump: RTL and testbench

Snapshot-and-dump engine that sits downstream of the CPU debug sampling mux. On a trigger it sweeps `Debug_addr` through all 32 channels, one per cycle, and latches each `Test_signal` word into a 32×32 buffer. It then streams the snapshot out of a UART TX pin as ASCII hex lines for a host terminal. While idle it passes the board's own debug address selection through, so the existing display path keeps working.

---
 rtl/debug_uart_dump.sv | 145 ++++++++++++++
 tb/tb_debug_uart_dump.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/debug_uart_dump.sv
// Snapshot engine: captures 32 debug channels on a trigger edge, then dumps them as ASCII hex lines over UART 8N1.
// Latency: capture takes 32 cycles; the first start bit follows at once. No backpressure: triggers while busy are dropped.
module debug_uart_dump #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger,
    input  logic [4:0]  ext_addr,
    input  logic [31:0] Test_signal,
    output logic [4:0]  Debug_addr,
    output logic        tx,
    output logic        busy,
    output logic        done
);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, SEND} state_t;

    state_t         state;
    logic [4:0]     k;
    logic [4:0]     line;
    logic [3:0]     chr;
    logic [3:0]     bit_cnt;
    logic [BW-1:0]  baud_cnt;
    logic [7:0]     sh;
    logic           trig_q;
    logic           trig_vld;
    logic [31:0]    snap_mem [32];

    logic [4:0]     nxt_line;
    logic [3:0]     nxt_chr;
    logic [31:0]    nxt_word;
    logic [2:0]     nib_idx;
    logic [3:0]     nib;
    logic [7:0]     nxt_byte;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign Debug_addr = (state == CAPTURE) ? k : ext_addr;

    // Next character to send, looked up from the indices that follow the current one.
    always_comb begin
        nxt_chr  = (chr == 4'd12) ? 4'd0 : chr + 4'd1;
        nxt_line = (chr == 4'd12) ? line + 5'd1 : line;
        nxt_word = snap_mem[nxt_line];
        nib_idx  = 3'(4'd10 - nxt_chr);
        nib      = nxt_word[{nib_idx, 2'b00} +: 4];
        nxt_byte = hex_ascii(nib);
        case (nxt_chr)
            4'd0:    nxt_byte = hex_ascii({3'b000, nxt_line[4]});
            4'd1:    nxt_byte = hex_ascii(nxt_line[3:0]);
            4'd2:    nxt_byte = 8'h20;
            4'd11:   nxt_byte = 8'h0D;
            4'd12:   nxt_byte = 8'h0A;
            default: nxt_byte = hex_ascii(nib);
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == CAPTURE)
            snap_mem[k] <= Test_signal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            k        <= 5'd0;
            line     <= 5'd0;
            chr      <= 4'd0;
            bit_cnt  <= 4'd0;
            baud_cnt <= '0;
            sh       <= 8'hFF;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            trig_q   <= 1'b0;
            trig_vld <= 1'b0;
        end else begin
            // trig_vld blocks a trigger that is already high coming out of reset.
            trig_q   <= trigger;
            trig_vld <= 1'b1;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (trigger && !trig_q && trig_vld) begin
                        state <= CAPTURE;
                        k     <= 5'd0;
                        busy  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    k <= k + 5'd1;
                    if (k == 5'd31) begin
                        state    <= SEND;
                        line     <= 5'd0;
                        chr      <= 4'd0;
                        bit_cnt  <= 4'd0;
                        baud_cnt <= '0;
                        sh       <= hex_ascii(4'd0);
                        tx       <= 1'b0;
                    end
                end
                SEND: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 4'd9) begin
                            if (line == 5'd31 && chr == 4'd12) begin
                                state <= IDLE;
                                tx    <= 1'b1;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                line    <= nxt_line;
                                chr     <= nxt_chr;
                                sh      <= nxt_byte;
                                bit_cnt <= 4'd0;
                                tx      <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd8) begin
                                tx <= 1'b1;
                            end else begin
                                tx <= sh[0];
                                sh <= {1'b0, sh[7:1]};
                            end
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_debug_uart_dump.sv
// Bench for debug_uart_dump: idle/reset vector table, capture sweep, UART decode against a character scoreboard.
module tb_debug_uart_dump;
    localparam int CPB = 4;
    localparam int SEND_CYCLES = 4160 * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trigger = 1'b1;
    logic [4:0]  ext_addr = 5'h07;
    logic [31:0] Test_signal;
    logic [4:0]  Debug_addr;
    logic        tx;
    logic        busy;
    logic        done;

    logic        force_ff = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          chars_rx = 0;
    logic [7:0]  exp_q [$];

    debug_uart_dump #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .ext_addr(ext_addr),
        .Test_signal(Test_signal), .Debug_addr(Debug_addr),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Model of the debug mux sitting in front of the DUT.
    always_comb Test_signal = force_ff ? 32'hFFFFFFFF : (32'hA5000000 | {27'd0, Debug_addr});

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] hx(input logic [3:0] n);
        logic [7:0] r;
        if (n < 4'd10) r = 8'h30 + {4'h0, n};
        else           r = 8'h41 + {4'h0, n} - 8'd10;
        return r;
    endfunction

    task automatic push_expected();
        for (int i = 0; i < 32; i++) begin
            logic [31:0] w;
            logic [7:0]  idx;
            w   = 32'hA5000000 | i;
            idx = 8'(i);
            exp_q.push_back(hx(idx[7:4]));
            exp_q.push_back(hx(idx[3:0]));
            exp_q.push_back(8'h20);
            for (int n = 7; n >= 0; n--) exp_q.push_back(hx(w[n*4 +: 4]));
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    // UART monitor: samples on falling edges, 4 samples per bit, all must agree.
    initial begin
        logic [7:0] by;
        logic       v;
        logic [7:0] e;
        bit         ok;
        bit         abort;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || tx !== 1'b0) continue;
            ok = 1; abort = 0; by = 8'h00; v = 1'b0;
            for (int b = 0; b < 10 && !abort; b++) begin
                for (int s = 0; s < CPB; s++) begin
                    if (!(b == 0 && s == 0)) @(negedge clk);
                    if (rst) abort = 1;
                    if (s == 0) v = tx;
                    else if (tx !== v) ok = 0;
                end
                if (b == 0 && v !== 1'b0) ok = 0;
                if (b == 9 && v !== 1'b1) ok = 0;
                if (b >= 1 && b <= 8) by[b-1] = v;
            end
            if (!abort) begin
                chk(ok, "uart_framing", {24'd0, by}, {24'd0, by});
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_char", {24'd0, by}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk(by === e, "uart_char", {24'd0, by}, {24'd0, e});
                end
                chars_rx++;
            end
        end
    end

    typedef struct {
        logic       rst;
        logic       trig;
        logic [4:0] ext;
        logic [4:0] exp_addr;
        logic       exp_tx;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    // abort_at > 0: assert rst that many cycles into SEND and expect an aborted frame.
    task automatic do_dump(input bit retrig, input int abort_at);
        int done_seen;
        int done_at;
        int addr_bad;
        int rx0;
        int limit;
        force_ff = 1'b0;
        ext_addr = 5'h07;
        push_expected();
        rx0 = chars_rx;
        trigger = 1'b1;
        @(posedge clk); #1;
        chk(busy === 1'b1, "busy_after_trigger", {31'd0, busy}, 32'd1);
        chk(Debug_addr === 5'd0, "sweep_addr", {27'd0, Debug_addr}, 32'd0);
        trigger = 1'b0;
        for (int i = 1; i < 32; i++) begin
            @(posedge clk); #1;
            chk(Debug_addr === 5'(i), "sweep_addr", {27'd0, Debug_addr}, i);
        end
        @(posedge clk); #1;
        chk(tx === 1'b0, "first_start_bit", {31'd0, tx}, 32'd0);
        force_ff = 1'b1;
        done_seen = 0; done_at = -1; addr_bad = 0;
        limit = (abort_at > 0) ? abort_at + 30 : SEND_CYCLES + 20;
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                done_seen++;
                done_at = n;
                chk(busy === 1'b0, "busy_drop_at_done", {31'd0, busy}, 32'd0);
            end
            if (Debug_addr !== ext_addr) addr_bad++;
            if (retrig && n == 100) trigger = 1'b1;
            if (retrig && n == 102) trigger = 1'b0;
            if (n == SEND_CYCLES - 1)
                chk(busy === 1'b1, "busy_during_send", {31'd0, busy}, 32'd1);
            if (abort_at > 0 && n == abort_at) rst = 1'b1;
            if (abort_at > 0 && n == abort_at + 1) begin
                chk(tx === 1'b1, "tx_after_abort", {31'd0, tx}, 32'd1);
                chk(busy === 1'b0, "busy_after_abort", {31'd0, busy}, 32'd0);
                rst = 1'b0;
            end
        end
        chk(addr_bad == 0, "no_capture_during_send", addr_bad, 32'd0);
        if (abort_at > 0) begin
            chk(done_seen == 0, "no_done_on_abort", done_seen, 32'd0);
            chk(chars_rx - rx0 == 39, "chars_before_abort", chars_rx - rx0, 32'd39);
            exp_q.delete();
        end else begin
            chk(done_seen == 1, "done_pulse_count", done_seen, 32'd1);
            chk(done_at == SEND_CYCLES, "done_timing", done_at, SEND_CYCLES);
            chk(chars_rx - rx0 == 416, "char_count", chars_rx - rx0, 32'd416);
            chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 32'd0);
        end
        force_ff = 1'b0;
    endtask

    initial begin
        vec_t vecs [7];
        vecs[0] = '{1'b1, 1'b1, 5'h07, 5'h07, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 5'h07, 5'h07, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 5'h07, 5'h07, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 5'h07, 5'h07, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 5'h1F, 5'h1F, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 5'h00, 5'h00, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 5'h15, 5'h15, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            rst      = vecs[i].rst;
            trigger  = vecs[i].trig;
            ext_addr = vecs[i].ext;
            @(posedge clk); #1;
            chk(Debug_addr === vecs[i].exp_addr, "vec_debug_addr", {27'd0, Debug_addr}, {27'd0, vecs[i].exp_addr});
            chk(tx === vecs[i].exp_tx, "vec_tx", {31'd0, tx}, {31'd0, vecs[i].exp_tx});
            chk(busy === vecs[i].exp_busy, "vec_busy", {31'd0, busy}, {31'd0, vecs[i].exp_busy});
            chk(done === vecs[i].exp_done, "vec_done", {31'd0, done}, {31'd0, vecs[i].exp_done});
        end
        // Combinational passthrough while idle: no clock edge between change and check.
        ext_addr = 5'h0A; #1;
        chk(Debug_addr === 5'h0A, "idle_passthrough", {27'd0, Debug_addr}, 32'h0A);
        @(posedge clk); #1;

        do_dump(1'b1, 0);
        repeat (5) @(posedge clk);
        #1;
        // Line 3 starts at char 39; 10 cycles in is inside a data bit.
        do_dump(1'b0, 39 * 10 * CPB + 10);
        repeat (5) @(posedge clk);
        #1;
        do_dump(1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk(busy === 1'b0, "idle_after_dump", {31'd0, busy}, 32'd0);
        chk(tx === 1'b1, "tx_idle_after_dump", {31'd0, tx}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
